dot_operand_fetch: RTL

Operand sequencer directly upstream of `dotProduct`. Holds two operand vector memories and, on a start request, streams `VECTOR_WIDTH` element pairs into `dotProduct` as `mem1_output`/`mem2_output`/`data_valid`. It then waits for `dotProduct` to report `result_valid` before accepting the next job, with a timeout guard. The output ports connect by name to `dotProduct`.

---
 rtl/dot_operand_fetch.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dot_operand_fetch.sv
// Operand sequencer feeding dotProduct: two synchronous-read operand memories and
// a four-state job FSM that streams VECTOR_WIDTH element pairs, then waits for the result.
module dot_operand_fetch #(
    parameter int DATA_WIDTH     = 8,
    parameter int VECTOR_WIDTH   = 4,
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr1,
    input  logic [ADDR_WIDTH-1:0] base_addr2,
    input  logic                  result_valid,
    output logic [DATA_WIDTH-1:0] mem1_output,
    output logic [DATA_WIDTH-1:0] mem2_output,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [1:0]            dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(VECTOR_WIDTH - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_mem1 [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_mem2 [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_addr1;
    logic [ADDR_WIDTH-1:0] r_addr2;
    logic [CW-1:0]         r_idx;
    logic [TW-1:0]         r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_rd1;
    logic [DATA_WIDTH-1:0] r_rd2;
    logic                  r_rd_valid;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_done;
    logic                  w_timeout;

    assign dbg_state = r_state;

    // data_valid is a pure valid strobe with no ready: dotProduct must take every
    // pair in the cycle it is presented; the stream cannot be stalled.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_issue = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // result_valid takes priority over an expiring timeout
                if (result_valid) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_wait_cnt == LAST_TICK) begin
                    w_done       = 1'b1;
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr1     <= '0;
            r_addr2     <= '0;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            r_rd_valid  <= 1'b0;
            mem1_output <= '0;
            mem2_output <= '0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr1 <= base_addr1;
                r_addr2 <= base_addr2;
                r_idx   <= '0;
            end else if (w_issue) begin
                // natural overflow gives the modulo-2^ADDR_WIDTH wrap
                r_addr1 <= r_addr1 + 1'b1;
                r_addr2 <= r_addr2 + 1'b1;
                r_idx   <= r_idx + 1'b1;
            end
            if (r_state != S_WAIT) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            r_rd_valid  <= w_issue;
            data_valid  <= r_rd_valid;
            mem1_output <= r_rd_valid ? r_rd1 : '0;
            mem2_output <= r_rd_valid ? r_rd2 : '0;
            busy        <= (w_next_state != S_IDLE) | w_done;
            done        <= w_done;
            timeout_err <= w_timeout;
        end
    end

    // Memory arrays are deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_sel) begin
            r_mem1[wr_addr] <= wr_data;
        end
        if (wr_en && wr_sel) begin
            r_mem2[wr_addr] <= wr_data;
        end
        if (w_issue) begin
            r_rd1 <= r_mem1[r_addr1];
            r_rd2 <= r_mem2[r_addr2];
        end
    end

endmodule
